frame_acq_ctrl: RTL and testbench

- Parametrised acquisition controller between the PDM audio decoder sample stream and the time-domain frame buffer feeding the FFT block.
- Generates the frame-rate tick internally.
- Captures 2^ADDR_W decimated samples per frame in one of three modes: free-run, single-shot or level trigger.
- Holds each completed frame behind a ready/ack handshake to the FFT side, and counts frame overruns.

---
 rtl/frame_acq_pkg.sv | 26 ++
 rtl/acq_prescaler.sv | 28 ++
 rtl/frame_acq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_frame_acq_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_acq_pkg.sv
// Shared encodings for the frame acquisition controller: FSM states, capture
// modes and the overrun saturation limit.
package frame_acq_pkg;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_START = 3'd1;
    localparam logic [2:0] S_WAIT_TRIG  = 3'd2;
    localparam logic [2:0] S_CAPTURE    = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;

    typedef enum logic [2:0] {
        StIdle      = S_IDLE,
        StWaitStart = S_WAIT_START,
        StWaitTrig  = S_WAIT_TRIG,
        StCapture   = S_CAPTURE,
        StDone      = S_DONE
    } acq_state_e;

    localparam logic [1:0] MODE_FREE   = 2'd0;
    localparam logic [1:0] MODE_SINGLE = 2'd1;
    localparam logic [1:0] MODE_TRIG   = 2'd2;
    localparam logic [1:0] MODE_OFF    = 2'd3;

    localparam logic [7:0] OVR_MAX = 8'd255;

endpackage

// File: rtl/acq_prescaler.sv
// Free-running divider producing a one-cycle tick every PRESC clocks; shared
// with the display refresh logic.
module acq_prescaler #(
    parameter int unsigned PRESC = 10000000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    output logic o_start_tick
);

    localparam int unsigned CNT_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESC - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_start_tick = (r_cnt == LAST);

endmodule

// File: rtl/frame_acq_ctrl.sv
// Acquisition controller: captures 2^ADDR_W decimated samples per frame into the
// FFT frame buffer in free-run, single-shot or level-trigger mode.
module frame_acq_ctrl
    import frame_acq_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned PRESC   = 10000000,
    parameter int unsigned DECIM_W = 4
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [1:0]         i_mode,
    input  logic               i_arm,
    input  logic               i_abort,
    input  logic [DECIM_W-1:0] i_decim,
    input  logic [DATA_W-1:0]  i_trig_level,
    input  logic               i_sample_valid,
    input  logic [DATA_W-1:0]  i_sample_data,
    output logic               o_buf_en,
    output logic               o_buf_we,
    output logic [ADDR_W-1:0]  o_buf_addr,
    output logic [DATA_W-1:0]  o_buf_din,
    output logic               o_frame_ready,
    input  logic               i_frame_ack,
    output logic               o_start_tick,
    output logic               o_busy,
    output logic [7:0]         o_overrun_cnt
);

    acq_state_e         r_state;
    logic [1:0]         r_mode_q;
    logic [DATA_W-1:0]  r_prev;
    logic               r_prev_ok;
    logic [DECIM_W-1:0] r_dcnt;
    logic [ADDR_W-1:0]  r_wptr;
    logic               r_buf_we;
    logic [ADDR_W-1:0]  r_buf_addr;
    logic [DATA_W-1:0]  r_buf_din;
    logic               r_frame_ready;
    logic [7:0]         r_ovr;

    logic w_tick;
    logic w_trig;
    logic w_last_wr;
    logic w_ovr_inc;

    acq_prescaler #(
        .PRESC(PRESC)
    ) u_prescaler (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .o_start_tick(w_tick)
    );

    assign w_trig = i_sample_valid && r_prev_ok
                    && ($signed(r_prev) < $signed(i_trig_level))
                    && ($signed(i_sample_data) >= $signed(i_trig_level));

    // The final address is on the buffer port this cycle; the frame is complete.
    assign w_last_wr = r_buf_we && (r_buf_addr == {ADDR_W{1'b1}});

    assign w_ovr_inc = w_tick && (r_mode_q == MODE_FREE)
                       && ((r_state == StCapture) || (r_state == StDone))
                       && (r_ovr != OVR_MAX);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state       <= StIdle;
            r_mode_q      <= '0;
            r_prev        <= '0;
            r_prev_ok     <= 1'b0;
            r_dcnt        <= '0;
            r_wptr        <= '0;
            r_buf_we      <= 1'b0;
            r_buf_addr    <= '0;
            r_buf_din     <= '0;
            r_frame_ready <= 1'b0;
            r_ovr         <= '0;
        end else begin
            r_buf_we <= 1'b0;
            if (i_sample_valid) begin
                r_prev    <= i_sample_data;
                r_prev_ok <= 1'b1;
            end
            if (i_abort) begin
                r_state       <= StIdle;
                r_wptr        <= '0;
                r_dcnt        <= '0;
                r_frame_ready <= 1'b0;
            end else begin
                if (w_ovr_inc) begin
                    r_ovr <= r_ovr + 1'b1;
                end
                unique case (r_state)
                    StIdle: begin
                        if (i_mode == MODE_FREE) begin
                            r_mode_q <= i_mode;
                            r_state  <= StWaitStart;
                        end else if (i_arm && (i_mode == MODE_SINGLE)) begin
                            r_mode_q <= i_mode;
                            r_state  <= StCapture;
                            r_wptr   <= '0;
                            r_dcnt   <= '0;
                        end else if (i_arm && (i_mode == MODE_TRIG)) begin
                            r_mode_q  <= i_mode;
                            r_state   <= StWaitTrig;
                            r_prev_ok <= 1'b0;
                        end
                    end
                    StWaitStart: begin
                        if (w_tick) begin
                            r_state <= StCapture;
                            r_wptr  <= '0;
                            r_dcnt  <= '0;
                        end
                    end
                    StWaitTrig: begin
                        // The triggering sample is the first accepted sample.
                        if (w_trig) begin
                            r_state    <= StCapture;
                            r_buf_we   <= 1'b1;
                            r_buf_addr <= '0;
                            r_buf_din  <= i_sample_data;
                            r_wptr     <= ADDR_W'(1);
                            r_dcnt     <= (i_decim == '0) ? '0 : DECIM_W'(1);
                        end
                    end
                    StCapture: begin
                        if (w_last_wr) begin
                            r_state       <= StDone;
                            r_frame_ready <= 1'b1;
                        end else if (i_sample_valid) begin
                            if (r_dcnt == '0) begin
                                r_buf_we   <= 1'b1;
                                r_buf_addr <= r_wptr;
                                r_buf_din  <= i_sample_data;
                                r_wptr     <= r_wptr + 1'b1;
                            end
                            r_dcnt <= (r_dcnt == i_decim) ? '0 : r_dcnt + 1'b1;
                        end
                    end
                    StDone: begin
                        if (i_frame_ack) begin
                            r_frame_ready <= 1'b0;
                            if ((i_mode != r_mode_q) || (r_mode_q != MODE_FREE)) begin
                                r_state <= StIdle;
                            end else begin
                                r_state <= StWaitStart;
                            end
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_buf_en      = r_buf_we;
    assign o_buf_we      = r_buf_we;
    assign o_buf_addr    = r_buf_addr;
    assign o_buf_din     = r_buf_din;
    assign o_frame_ready = r_frame_ready;
    assign o_start_tick  = w_tick;
    assign o_busy        = (r_state != StIdle);
    assign o_overrun_cnt = r_ovr;

endmodule

// File: tb/tb_frame_acq_ctrl.sv
// Bench for frame_acq_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_frame_acq_ctrl;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 3;
    localparam int PRESC   = 20;
    localparam int DECIM_W = 4;
    localparam int FRAME   = 1 << ADDR_W;

    localparam int PH_IDLE = 0;
    localparam int PH_WS   = 1;
    localparam int PH_WT   = 2;
    localparam int PH_CAP  = 3;
    localparam int PH_DONE = 4;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [1:0]         mode = 2'd3;
    logic               arm = 1'b0;
    logic               abort = 1'b0;
    logic [DECIM_W-1:0] decim = '0;
    logic [DATA_W-1:0]  trig_level = '0;
    logic               sample_valid = 1'b0;
    logic [DATA_W-1:0]  sample_data = '0;
    logic               frame_ack = 1'b0;
    logic               buf_en;
    logic               buf_we;
    logic [ADDR_W-1:0]  buf_addr;
    logic [DATA_W-1:0]  buf_din;
    logic               frame_ready;
    logic               start_tick;
    logic               busy;
    logic [7:0]         overrun_cnt;

    frame_acq_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .PRESC  (PRESC),
        .DECIM_W(DECIM_W)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_mode        (mode),
        .i_arm         (arm),
        .i_abort       (abort),
        .i_decim       (decim),
        .i_trig_level  (trig_level),
        .i_sample_valid(sample_valid),
        .i_sample_data (sample_data),
        .o_buf_en      (buf_en),
        .o_buf_we      (buf_we),
        .o_buf_addr    (buf_addr),
        .o_buf_din     (buf_din),
        .o_frame_ready (frame_ready),
        .i_frame_ack   (frame_ack),
        .o_start_tick  (start_tick),
        .o_busy        (busy),
        .o_overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Behavioural model: what the outputs must be after each clock edge.
    int                       m_cnt = 0;
    int                       m_ph = PH_IDLE;
    int                       m_mode_q = 0;
    int                       m_skip = 0;
    int                       m_n = 0;
    int                       m_ovr = 0;
    bit                       m_prev_ok = 0;
    bit                       m_fin = 0;
    bit                       m_rst = 1;
    logic signed [DATA_W-1:0] m_prev = '0;
    bit                       e_we = 0;
    bit                       e_ready = 0;
    int                       e_addr = 0;
    logic [DATA_W-1:0]        e_din = '0;

    always @(posedge clk) begin : model
        bit tick_now;
        bit fire;
        tick_now = (m_cnt == PRESC - 1);
        e_we = 0;
        if (!reset_n) begin
            m_cnt = 0; m_ph = PH_IDLE; m_mode_q = 0; m_skip = 0; m_n = 0; m_ovr = 0;
            m_prev_ok = 0; m_fin = 0; m_prev = '0; e_ready = 0; e_addr = 0; e_din = '0;
            m_rst = 1;
        end else begin
            m_rst = 0;
            m_cnt = tick_now ? 0 : m_cnt + 1;
            fire = sample_valid && m_prev_ok && (m_prev < $signed(trig_level))
                   && ($signed(sample_data) >= $signed(trig_level));
            if (sample_valid) begin
                m_prev = sample_data;
                m_prev_ok = 1;
            end
            if (abort) begin
                m_ph = PH_IDLE; m_n = 0; m_fin = 0; e_ready = 0;
            end else begin
                if (tick_now && m_mode_q == 0 && (m_ph == PH_CAP || m_ph == PH_DONE)
                    && m_ovr < 255) m_ovr++;
                case (m_ph)
                    PH_IDLE: begin
                        if (mode == 0) begin
                            m_mode_q = 0; m_ph = PH_WS;
                        end else if (arm && mode == 1) begin
                            m_mode_q = 1; m_ph = PH_CAP; m_n = 0; m_skip = 0; m_fin = 0;
                        end else if (arm && mode == 2) begin
                            m_mode_q = 2; m_ph = PH_WT; m_prev_ok = 0;
                        end
                    end
                    PH_WS: if (tick_now) begin
                        m_ph = PH_CAP; m_n = 0; m_skip = 0; m_fin = 0;
                    end
                    PH_WT: if (fire) begin
                        m_ph = PH_CAP; e_we = 1; e_addr = 0; e_din = sample_data;
                        m_n = 1; m_skip = int'(decim); m_fin = (FRAME == 1);
                    end
                    PH_CAP: begin
                        if (m_fin) begin
                            m_ph = PH_DONE; e_ready = 1;
                        end else if (sample_valid) begin
                            if (m_skip == 0) begin
                                e_we = 1; e_addr = m_n; e_din = sample_data;
                                m_n++; m_skip = int'(decim); m_fin = (m_n == FRAME);
                            end else begin
                                m_skip--;
                            end
                        end
                    end
                    PH_DONE: if (frame_ack) begin
                        e_ready = 0;
                        m_ph = (int'(mode) != m_mode_q || m_mode_q != 0) ? PH_IDLE : PH_WS;
                    end
                    default: m_ph = PH_IDLE;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("start_tick", start_tick, m_cnt == PRESC - 1);
            chk("busy", busy, m_ph != PH_IDLE);
            chk("buf_we", buf_we, e_we);
            chk("buf_en", buf_en, e_we);
            chk("frame_ready", frame_ready, e_ready);
            chk("overrun_cnt", overrun_cnt, m_ovr);
            if (e_we || m_rst) begin
                chk("buf_addr", buf_addr, e_addr);
                chk("buf_din", buf_din, e_din);
            end
        end
    end

    logic [ADDR_W-1:0] wq_a[$];
    logic [DATA_W-1:0] wq_d[$];

    always @(negedge clk) begin
        if (buf_we) begin
            wq_a.push_back(buf_addr);
            wq_d.push_back(buf_din);
        end
    end

    task automatic clear_q();
        wq_a.delete();
        wq_d.delete();
    endtask

    task automatic do_reset(input int unsigned new_decim);
        reset_n = 1'b0;
        decim = DECIM_W'(new_decim);
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic wait_ready(input string name, input int bound);
        for (int i = 0; i < bound && !frame_ready; i++) step();
        chk(name, frame_ready, 1);
    endtask

    task automatic wait_addr3(input string name);
        for (int i = 0; i < 80 && !(buf_we && buf_addr == 3); i++) step();
        chk(name, buf_we && buf_addr == 3, 1);
    endtask

    initial begin
        int  cyc;
        int  first_tick;
        int  d;
        bit  started;
        bit  prev_tick;
        int  trig_seq[5] = '{120, 90, 95, 105, 110};

        // Reset with arbitrary inputs.
        for (int i = 0; i < 6; i++) begin
            step();
            chk_on = 1;
            mode = 2'($urandom); arm = 1'($urandom); abort = 1'($urandom);
            sample_valid = 1'($urandom); sample_data = 16'($urandom);
            frame_ack = 1'($urandom); trig_level = 16'($urandom);
            chk("rst_busy", busy, 0);
            chk("rst_we", buf_we, 0);
            chk("rst_ready", frame_ready, 0);
            chk("rst_ovr", overrun_cnt, 0);
            chk("rst_tick", start_tick, 0);
        end
        mode = 2'd3; arm = 0; abort = 0; sample_valid = 0; frame_ack = 0;
        sample_data = '0; trig_level = '0;

        // First tick: the release cycle counts as cycle 1.
        reset_n = 1'b1;
        cyc = 1;
        first_tick = 0;
        for (int i = 0; i < 40 && first_tick == 0; i++) begin
            if (start_tick) first_tick = cyc;
            else begin
                step();
                cyc++;
            end
        end
        chk("first_tick_cycle", first_tick, 20);

        // Free-run, decim 0, data = running cycle count.
        mode = 2'd0; sample_valid = 1'b1; d = 0; sample_data = '0;
        clear_q();
        for (int i = 0; i < 80 && !frame_ready; i++) begin
            step();
            d++;
            sample_data = 16'(d);
        end
        chk("fr_ready", frame_ready, 1);
        chk("fr_nwrites", wq_a.size(), 8);
        for (int k = 0; k < 8 && k < wq_a.size(); k++) begin
            chk("fr_addr", wq_a[k], k);
            chk("fr_consec", wq_d[k] - wq_d[0], k);
        end
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        chk("fr_ack_busy", busy, 1);
        chk("fr_ack_ready", frame_ready, 0);
        clear_q();
        for (int i = 0; i < 3 * PRESC && wq_a.size() == 0; i++) step();
        chk("fr_restart_n", wq_a.size(), 1);
        if (wq_a.size() > 0) chk("fr_restart_addr", wq_a[0], 0);

        // Decimation 2, data 0,1,2,... from the first capture cycle.
        do_reset(2);
        mode = 2'd0; sample_valid = 1'b1; d = 0; started = 0; prev_tick = 0;
        clear_q();
        for (int i = 0; i < 120 && !frame_ready; i++) begin
            step();
            if (prev_tick && !started) begin
                started = 1;
                d = 0;
            end else begin
                d++;
            end
            sample_data = 16'(d);
            prev_tick = (m_cnt == PRESC - 1);
        end
        chk("dec_nwrites", wq_a.size(), 8);
        for (int k = 0; k < 8 && k < wq_a.size(); k++) begin
            chk("dec_addr", wq_a[k], k);
            chk("dec_data", wq_d[k], 3 * k);
        end

        // Level trigger.
        do_reset(0);
        mode = 2'd2; trig_level = 16'd100; arm = 1'b1; sample_valid = 1'b0;
        clear_q();
        step();
        arm = 1'b0;
        sample_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sample_data = 16'(trig_seq[k]);
            step();
        end
        for (int i = 0; i < 40 && !frame_ready; i++) begin
            sample_data = sample_data + 16'd1;
            step();
        end
        chk("trg_ready", frame_ready, 1);
        chk("trg_nwrites", wq_a.size(), 8);
        if (wq_a.size() >= 2) begin
            chk("trg_addr0", wq_a[0], 0);
            chk("trg_data0", wq_d[0], 105);
            chk("trg_addr1", wq_a[1], 1);
            chk("trg_data1", wq_d[1], 110);
        end
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        chk("trg_idle", busy, 0);

        // Overrun counting and saturation.
        do_reset(0);
        mode = 2'd0; sample_valid = 1'b1;
        wait_ready("ovr_ready", 80);
        repeat (3 * PRESC) step();
        chk("ovr_three", overrun_cnt, 3);
        repeat (297 * PRESC) step();
        chk("ovr_sat", overrun_cnt, 255);
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;

        // Abort at the fourth write.
        do_reset(0);
        mode = 2'd0; sample_valid = 1'b1;
        wait_addr3("abt_reach");
        abort = 1'b1;
        mode = 2'd3;
        step();
        abort = 1'b0;
        chk("abt_we", buf_we, 0);
        chk("abt_busy", busy, 0);
        chk("abt_ready", frame_ready, 0);
        mode = 2'd0;
        clear_q();
        for (int i = 0; i < 3 * PRESC && wq_a.size() == 0; i++) step();
        chk("abt_wptr0", (wq_a.size() > 0) ? int'(wq_a[0]) : -1, 0);

        // Reset at the fourth write.
        wait_addr3("rmc_reach");
        reset_n = 1'b0;
        step();
        chk("rmc_we", buf_we, 0);
        chk("rmc_en", buf_en, 0);
        chk("rmc_busy", busy, 0);
        chk("rmc_ready", frame_ready, 0);
        chk("rmc_addr", buf_addr, 0);
        chk("rmc_din", buf_din, 0);
        chk("rmc_ovr", overrun_cnt, 0);
        reset_n = 1'b1;

        // Randomized traffic against the model.
        for (int ep = 0; ep < 8; ep++) begin
            do_reset($urandom_range(3));
            trig_level = 16'(int'($urandom_range(100)) - 50);
            for (int c = 0; c < 600; c++) begin
                mode = 2'($urandom_range(3));
                arm = ($urandom_range(99) < 15);
                abort = ($urandom_range(199) < 2);
                sample_valid = ($urandom_range(99) < 75);
                sample_data = 16'(int'($urandom_range(240)) - 120);
                frame_ack = ($urandom_range(99) < 25);
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
